// File: rtl/register_file_param.sv
// Parametrised N-read / 1-write flop-based register file with write-to-read
// bypass and a hardware clear sequencer. It sits between writeback and decode.
// rf_read_port is one combinational read lane; the top replicates it N_READ times.

module rf_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                                busy,
  input  logic [ADDR_W-1:0]                   rd_addr,
  input  logic                                wr_ena,
  input  logic [ADDR_W-1:0]                   wr_addr,
  input  logic [DATA_W-1:0]                   wr_data,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]  mem,
  output logic [DATA_W-1:0]                   rd_data
);

  // Priority: clear window, hardwired zero, same-cycle writeback, stored entry
  always_comb begin
    rd_data = mem[rd_addr];
    if (busy)
      rd_data = '0;
    else if ((ZERO_REG != 0) && (rd_addr == '0))
      rd_data = '0;
    else if (wr_ena && (rd_addr == wr_addr))
      rd_data = wr_data;
  end

endmodule

module register_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_READ   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_req,
  output logic                       busy,
  input  logic                       wr_ena,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [N_READ*ADDR_W-1:0]   rd_addr,
  output logic [N_READ*DATA_W-1:0]   rd_data
);

  localparam int                DEPTH = 1 << ADDR_W;
  // Entry 0 never needs clearing when it is hardwired to zero
  localparam logic [ADDR_W-1:0] FIRST = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                         state;
  logic [ADDR_W-1:0]              clr_ptr;
  logic [DEPTH-1:0][DATA_W-1:0]   mem;
  logic                           wr_commit;

  // busy comes straight off the state flop so it reads 1 the moment rst rises
  assign busy = (state == S_CLEAR);

  // Writes are dropped during clear; entry 0 writes vanish when hardwired
  assign wr_commit = wr_ena && !busy && !((ZERO_REG != 0) && (wr_addr == '0));

  // Clear sequencer: walk FIRST..DEPTH-1 once, then idle until clr_req
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_ptr <= FIRST;
    end else begin
      case (state)
        S_CLEAR: begin
          // Pointer parks at LAST rather than wrapping; clr_req is ignored here
          if (clr_ptr == LAST) state <= S_IDLE;
          else                 clr_ptr <= clr_ptr + ADDR_W'(1);
        end
        S_IDLE: begin
          if (clr_req) begin
            state   <= S_CLEAR;
            clr_ptr <= FIRST;
          end
        end
        default: begin
          state   <= S_CLEAR;
          clr_ptr <= FIRST;
        end
      endcase
    end
  end

  // Storage has no reset; the sequencer is the only thing that initialises it
  always_ff @(posedge clk) begin
    if (busy)
      mem[clr_ptr] <= '0;
    else if (wr_commit)
      mem[wr_addr] <= wr_data;
  end

  // One independent read lane per port
  for (genvar g = 0; g < N_READ; g++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .busy    (busy),
      .rd_addr (rd_addr[g*ADDR_W +: ADDR_W]),
      .wr_ena  (wr_ena),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .mem     (mem),
      .rd_data (rd_data[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench: stimulus pushes expected busy/read values, a negedge
// monitor pops and compares them against the DUT outputs.

module tb_register_file_param;

  logic        clk;
  // DUT A: default parameters
  logic        rst_a, clr_a, busy_a, wr_ena_a;
  logic [4:0]  wr_addr_a;
  logic [31:0] wr_data_a;
  logic [9:0]  rd_addr_a;
  logic [63:0] rd_data_a;
  // DUT B: ZERO_REG=0, N_READ=3
  logic        rst_b, clr_b, busy_b, wr_ena_b;
  logic [4:0]  wr_addr_b;
  logic [31:0] wr_data_b;
  logic [14:0] rd_addr_b;
  logic [95:0] rd_data_b;

  register_file_param u_dut_a (
    .clk(clk), .rst(rst_a), .clr_req(clr_a), .busy(busy_a),
    .wr_ena(wr_ena_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a)
  );

  register_file_param #(.DATA_W(32), .ADDR_W(5), .N_READ(3), .ZERO_REG(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .clr_req(clr_b), .busy(busy_b),
    .wr_ena(wr_ena_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit              dut;
    logic            busy;
    logic [2:0][31:0] rd;
    int              np;
    string           nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic vec_vld;
  int   n_vec;
  int   n_bad;
  logic        got_busy;
  logic [31:0] got_rd;

  // Monitor: pop every record issued this cycle and compare
  always @(negedge clk) begin
    if (vec_vld) begin
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow got 0 records want >=1");
      end
      while (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_vec++;
        got_busy = mon_e.dut ? busy_b : busy_a;
        if (got_busy !== mon_e.busy) begin
          n_bad++;
          $display("FAIL %s busy got %0b want %0b", mon_e.nm, got_busy, mon_e.busy);
        end
        for (int p = 0; p < 3; p++) begin
          if (p < mon_e.np) begin
            got_rd = mon_e.dut ? rd_data_b[p*32 +: 32] : rd_data_a[p*32 +: 32];
            if (got_rd !== mon_e.rd[p]) begin
              n_bad++;
              $display("FAIL %s rd%0d got %h want %h", mon_e.nm, p, got_rd, mon_e.rd[p]);
            end
          end
        end
      end
    end
  end

  task automatic vec(input bit d, input logic b, input logic [31:0] r0, input logic [31:0] r1,
                     input logic [31:0] r2, input int np, input string nm);
    exp_t e;
    e.dut = d; e.busy = b; e.rd[0] = r0; e.rd[1] = r1; e.rd[2] = r2; e.np = np; e.nm = nm;
    exp_q.push_back(e);
    vec_vld = 1'b1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    vec_vld = 1'b0;
  endtask

  task automatic ra(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr_a = {a1, a0};
  endtask

  task automatic wa(input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_ena_a = en; wr_addr_a = a; wr_data_a = d;
  endtask

  initial begin
    vec_vld = 1'b0; n_vec = 0; n_bad = 0;
    rst_a = 1'b0; clr_a = 1'b0; wa(1'b0, 5'd0, 32'h0); rd_addr_a = '0;
    rst_b = 1'b0; clr_b = 1'b0; wr_ena_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; rd_addr_b = '0;
    #2;
    rst_a = 1'b1; rst_b = 1'b1;
    #1;

    // Reset state on both instances
    ra(5'd3, 5'd7);
    rd_addr_b = {5'd2, 5'd1, 5'd0};
    vec(0, 1'b1, 0, 0, 0, 2, "rst_a");
    vec(1, 1'b1, 0, 0, 0, 3, "rst_b");
    step;
    vec(0, 1'b1, 0, 0, 0, 2, "rst_a_hold");
    step;

    // Boot clear: busy for exactly 31 edges after release, reads 0 throughout
    rst_a = 1'b0;
    for (int k = 0; k < 32; k++) begin
      ra(5'(k), 5'(31 - k));
      vec(0, k < 31, 0, 0, 0, 2, "boot_clear");
      step;
    end
    for (int i = 0; i < 32; i++) begin
      ra(5'(i), 5'(31 - i));
      vec(0, 1'b0, 0, 0, 0, 2, "boot_zero");
      step;
    end

    // Bypass then stored value
    wa(1'b1, 5'd5, 32'hDEADBEEF); ra(5'd5, 5'd5);
    vec(0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2, "bypass_x5");
    step;
    wa(1'b0, 5'd0, 32'h0);
    vec(0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2, "stored_x5");
    step;

    // x0 hardwired
    wa(1'b1, 5'd0, 32'h12345678); ra(5'd0, 5'd5);
    vec(0, 1'b0, 0, 32'hDEADBEEF, 0, 2, "x0_wr_cycle");
    step;
    wa(1'b0, 5'd0, 32'h0);
    vec(0, 1'b0, 0, 32'hDEADBEEF, 0, 2, "x0_after");
    step;

    // Fill x1..x31 = addr, port0 bypass, port1 previous entry
    for (int i = 1; i < 32; i++) begin
      wa(1'b1, 5'(i), 32'(i)); ra(5'(i), 5'(i - 1));
      vec(0, 1'b0, 32'(i), 32'(i - 1), 0, 2, "fill");
      step;
    end
    wa(1'b0, 5'd0, 32'h0); ra(5'd9, 5'd31);
    vec(0, 1'b0, 32'd9, 32'd31, 0, 2, "fill_check");
    step;

    // Write plus clr_req on the same idle edge: write commits, clear wins later
    wa(1'b1, 5'd3, 32'h77); clr_a = 1'b1; ra(5'd3, 5'd31);
    vec(0, 1'b0, 32'h77, 32'd31, 0, 2, "wr_with_clr");
    step;
    clr_a = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      wa(1'b0, 5'd0, 32'h0);
      clr_a = (k == 15);                        // ignored mid-clear
      if (k == 5)  wa(1'b1, 5'd7, 32'hAA);      // dropped while busy
      if (k == 31) wa(1'b1, 5'd9, 32'h99);      // dropped on final clear cycle
      ra(5'd7, 5'd3);
      vec(0, k <= 31, 0, 0, 0, 2, "req_clear");
      step;
    end
    clr_a = 1'b0; wa(1'b0, 5'd0, 32'h0);
    ra(5'd9, 5'd31);
    vec(0, 1'b0, 0, 0, 0, 2, "final_wr_drop");
    step;
    for (int i = 0; i < 32; i++) begin
      ra(5'(i), 5'(31 - i));
      vec(0, 1'b0, 0, 0, 0, 2, "clear_zero");
      step;
    end

    // Reset in the middle of a clear restarts the full sequence
    wa(1'b1, 5'd4, 32'h44); ra(5'd4, 5'd4);
    vec(0, 1'b0, 32'h44, 32'h44, 0, 2, "pre_x4");
    step;
    wa(1'b0, 5'd0, 32'h0); clr_a = 1'b1;
    vec(0, 1'b0, 32'h44, 32'h44, 0, 2, "pre_clr_x4");
    step;
    clr_a = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      vec(0, 1'b1, 0, 0, 0, 2, "clear_pre_rst");
      step;
    end
    rst_a = 1'b1;
    vec(0, 1'b1, 0, 0, 0, 2, "mid_rst");
    step;
    rst_a = 1'b0;
    for (int j = 0; j < 32; j++) begin
      vec(0, j < 31, 0, 0, 0, 2, "restart_clear");
      step;
    end
    vec(0, 1'b0, 0, 0, 0, 2, "x4_cleared");
    step;

    // ZERO_REG=0, N_READ=3: 32-cycle clear and ordinary x0
    rst_b = 1'b0;
    for (int j = 0; j < 33; j++) begin
      rd_addr_b = {5'd31, 5'd16, 5'd0};
      vec(1, j < 32, 0, 0, 0, 3, "b_clear");
      step;
    end
    wr_ena_b = 1'b1; wr_addr_b = 5'd0; wr_data_b = 32'h55;
    rd_addr_b = {5'd0, 5'd0, 5'd0};
    vec(1, 1'b0, 32'h55, 32'h55, 32'h55, 3, "b_x0_bypass");
    step;
    wr_ena_b = 1'b0;
    vec(1, 1'b0, 32'h55, 32'h55, 32'h55, 3, "b_x0_stored");
    step;
    rd_addr_b = {5'd16, 5'd0, 5'd31};
    vec(1, 1'b0, 0, 32'h55, 0, 3, "b_mixed");
    step;

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover got %0d records want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
